// File: rtl/reg_sb_pkg.sv
// Shared sizing and types for the register scoreboard.
package reg_sb_pkg;
  localparam int NREGS  = 32;
  localparam int AW     = $clog2(NREGS);
  localparam int CNT_W  = 2;
  localparam int STAT_W = 16;

  typedef logic [AW-1:0]    reg_idx_t;
  typedef logic [CNT_W-1:0] sb_cnt_t;

  localparam sb_cnt_t CNT_MAX = '1;
endpackage

// File: rtl/reg_sb_cnt.sv
// Per-register saturating pending-write counter.
// REG_SCOREBOARD_BYPASS_EN: src_busy drops in the cycle the last pending write retires.
module reg_sb_cnt
  import reg_sb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  output logic busy,
  output logic src_busy,
  output logic at_max,
  output logic underflow
);

  sb_cnt_t cnt;
  logic    do_inc;
  logic    do_dec;

  assign busy      = (cnt != '0);
  assign at_max    = (cnt == CNT_MAX);
  assign underflow = dec & ~busy;
  assign do_inc    = inc & ~at_max;
  assign do_dec    = dec & busy;

`ifdef REG_SCOREBOARD_BYPASS_EN
  // Retiring the only outstanding write: datapath forwards the wb value.
  assign src_busy = busy & ~(dec & (cnt == sb_cnt_t'(1)));
`else
  assign src_busy = busy;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (do_inc && !do_dec) begin
      cnt <= cnt + 1'b1;
    end else if (do_dec && !do_inc) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// RAW-hazard scoreboard for the integer register file: hazard decode, stall,
// stall statistics and sticky underflow flag. Optional macro: REG_SCOREBOARD_BYPASS_EN.
module reg_scoreboard
  import reg_sb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [AW-1:0]     issue_rs1,
  input  logic [AW-1:0]     issue_rs2,
  input  logic [AW-1:0]     issue_rd,
  input  logic              issue_use_rs1,
  input  logic              issue_use_rs2,
  input  logic              issue_wr_rd,
  output logic              issue_stall,
  input  logic              wb_valid,
  input  logic [AW-1:0]     wb_rd,
  input  logic              flush,
  output logic [NREGS-1:0]  busy_vec,
  output logic              sb_empty,
  output logic              err_underflow,
  output logic [STAT_W-1:0] stall_cycles
);

  logic [NREGS-1:0] busy_w;
  logic [NREGS-1:0] src_busy_w;
  logic [NREGS-1:0] at_max_w;
  logic [NREGS-1:0] uflow_w;
  logic             haz1;
  logic             haz2;
  logic             full;
  logic             accept;

  // x0 is hard-wired zero and never tracked.
  assign busy_w[0]     = 1'b0;
  assign src_busy_w[0] = 1'b0;
  assign at_max_w[0]   = 1'b0;
  assign uflow_w[0]    = 1'b0;

  assign haz1   = issue_use_rs1 & (issue_rs1 != '0) & src_busy_w[issue_rs1];
  assign haz2   = issue_use_rs2 & (issue_rs2 != '0) & src_busy_w[issue_rs2];
  assign full   = issue_wr_rd & (issue_rd != '0) & at_max_w[issue_rd];

  assign issue_stall = issue_valid & (haz1 | haz2 | full);
  assign accept      = issue_valid & ~issue_stall & ~flush;

  for (genvar i = 1; i < NREGS; i++) begin : g_cnt
    reg_sb_cnt u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (accept & issue_wr_rd & (issue_rd == AW'(i))),
      .dec       (~flush & wb_valid & (wb_rd == AW'(i))),
      .clr       (flush),
      .busy      (busy_w[i]),
      .src_busy  (src_busy_w[i]),
      .at_max    (at_max_w[i]),
      .underflow (uflow_w[i])
    );
  end

  assign busy_vec = busy_w;
  assign sb_empty = ~|busy_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_underflow <= 1'b0;
      stall_cycles  <= '0;
    end else begin
      if (|uflow_w) begin
        err_underflow <= 1'b1;
      end
      if (issue_stall && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: vector table plus corner-case sequences,
// registered outputs compared through an expected-value queue.
module tb_reg_scoreboard;
  import reg_sb_pkg::*;

`ifdef REG_SCOREBOARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              issue_valid;
  reg_idx_t          issue_rs1, issue_rs2, issue_rd;
  logic              issue_use_rs1, issue_use_rs2, issue_wr_rd;
  logic              issue_stall;
  logic              wb_valid;
  reg_idx_t          wb_rd;
  logic              flush;
  logic [NREGS-1:0]  busy_vec;
  logic              sb_empty;
  logic              err_underflow;
  logic [STAT_W-1:0] stall_cycles;

  reg_scoreboard dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid   (issue_valid),
    .issue_rs1     (issue_rs1),
    .issue_rs2     (issue_rs2),
    .issue_rd      (issue_rd),
    .issue_use_rs1 (issue_use_rs1),
    .issue_use_rs2 (issue_use_rs2),
    .issue_wr_rd   (issue_wr_rd),
    .issue_stall   (issue_stall),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .flush         (flush),
    .busy_vec      (busy_vec),
    .sb_empty      (sb_empty),
    .err_underflow (err_underflow),
    .stall_cycles  (stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic     v;
    reg_idx_t rs1, rs2, rd;
    logic     u1, u2, wr, wbv;
    reg_idx_t wbrd;
    logic     fl;
    logic     exp_stall;
  } vec_t;

  typedef struct {
    logic [NREGS-1:0]  busy;
    logic              empty;
    logic              err;
    logic [STAT_W-1:0] sc;
  } exp_t;

  int   checks   = 0;
  int   failures = 0;
  int   m_cnt [NREGS];
  bit   m_err;
  int   m_sc;
  exp_t expq [$];
  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input int rs1, input int rs2, input int rd,
                              input logic u1, input logic u2, input logic wr,
                              input logic wbv, input int wbrd, input logic fl, input logic es);
    vec_t r;
    r.v = v; r.rs1 = reg_idx_t'(rs1); r.rs2 = reg_idx_t'(rs2); r.rd = reg_idx_t'(rd);
    r.u1 = u1; r.u2 = u2; r.wr = wr; r.wbv = wbv; r.wbrd = reg_idx_t'(wbrd);
    r.fl = fl; r.exp_stall = es;
    return r;
  endfunction

  function automatic exp_t model_snapshot();
    exp_t e;
    e.busy = '0;
    for (int i = 1; i < NREGS; i++) e.busy[i] = (m_cnt[i] != 0);
    e.empty = (e.busy == '0);
    e.err   = m_err;
    e.sc    = STAT_W'(m_sc);
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_cnt[i] = 0;
    m_err = 1'b0;
    m_sc  = 0;
  endtask

  // One clock: drive at negedge, check stall combinationally, advance model, check registered outputs.
  task automatic tick(input vec_t v, input string name, input bit chk_on);
    exp_t e, got;
    bit   inc, dec;
    @(negedge clk);
    issue_valid = v.v; issue_rs1 = v.rs1; issue_rs2 = v.rs2; issue_rd = v.rd;
    issue_use_rs1 = v.u1; issue_use_rs2 = v.u2; issue_wr_rd = v.wr;
    wb_valid = v.wbv; wb_rd = v.wbrd; flush = v.fl;
    #1;
    if (chk_on) chk({name, "_stall"}, 32'(issue_stall), 32'(v.exp_stall));
    if (v.exp_stall && m_sc < (1 << STAT_W) - 1) m_sc++;
    if (v.fl) begin
      for (int i = 0; i < NREGS; i++) m_cnt[i] = 0;
    end else begin
      inc = v.v && !v.exp_stall && v.wr && (v.rd != 0);
      dec = v.wbv && (v.wbrd != 0) && (m_cnt[v.wbrd] != 0);
      if (v.wbv && v.wbrd != 0 && m_cnt[v.wbrd] == 0) m_err = 1'b1;
      if (inc) m_cnt[v.rd]++;
      if (dec) m_cnt[v.wbrd]--;
    end
    expq.push_back(model_snapshot());
    @(posedge clk);
    #1;
    if (expq.size() == 0) begin
      chk({name, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = expq.pop_front();
      got.busy = busy_vec;
      if (chk_on) begin
        chk({name, "_busy"},  got.busy,           e.busy);
        chk({name, "_empty"}, 32'(sb_empty),      32'(e.empty));
        chk({name, "_err"},   32'(err_underflow), 32'(e.err));
        chk({name, "_sc"},    32'(stall_cycles),  32'(e.sc));
      end
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
    issue_use_rs1 = 0; issue_use_rs2 = 0; issue_wr_rd = 0;
    wb_valid = 0; wb_rd = 0; flush = 0;
    model_reset();

    // RAW hazard, x0, underflow, unused-source and invalid-issue cases.
    tbl[0]  = mk(1, 0, 0, 5, 0, 0, 1, 0, 0, 0, 0);
    tbl[1]  = mk(1, 5, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    tbl[2]  = mk(1, 5, 0, 0, 1, 0, 0, 1, 5, 0, BYP ? 1'b0 : 1'b1);
    tbl[3]  = mk(1, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[7]  = mk(1, 0, 5, 6, 0, 1, 1, 0, 0, 0, 0);
    tbl[8]  = mk(1, 0, 6, 0, 1, 1, 0, 0, 0, 0, 1);
    tbl[9]  = mk(1, 0, 6, 8, 0, 0, 1, 1, 6, 0, 0);
    tbl[10] = mk(0, 8, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 1, 8, 0, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy",  busy_vec, '0);
    chk("reset_empty", 32'(sb_empty), 32'd1);
    chk("reset_err",   32'(err_underflow), 32'd0);
    chk("reset_sc",    32'(stall_cycles), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) tick(tbl[i], $sformatf("vec%0d", i), 1'b1);

    // Saturation on x7: three writes fill it, fourth stalls, full is not bypassed by wb.
    for (int i = 0; i < 3; i++) tick(mk(1, 0, 0, 7, 0, 0, 1, 0, 0, 0, 0), "sat_fill", 1'b1);
    tick(mk(1, 0, 0, 7, 0, 0, 1, 0, 0, 0, 1), "sat_full", 1'b1);
    tick(mk(1, 0, 0, 7, 0, 0, 1, 1, 7, 0, 1), "sat_full_wb", 1'b1);
    tick(mk(1, 0, 0, 7, 0, 0, 1, 0, 0, 0, 0), "sat_accept", 1'b1);
    tick(mk(1, 0, 0, 7, 0, 0, 1, 0, 0, 0, 1), "sat_back_to3", 1'b1);
    for (int i = 0; i < 3; i++) tick(mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0), "sat_drain", 1'b1);

    // Simultaneous issue and retire on x9 leaves the count at 1.
    tick(mk(1, 0, 0, 9, 0, 0, 1, 0, 0, 0, 0), "sim_set", 1'b1);
    tick(mk(1, 0, 0, 9, 0, 0, 1, 1, 9, 0, 0), "sim_both", 1'b1);
    tick(mk(1, 9, 0, 0, 1, 0, 0, 0, 0, 0, 1), "sim_still1", 1'b1);
    tick(mk(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0), "sim_drain", 1'b1);

    // Flush with four busy registers; issue and wb in the flush cycle are ignored.
    for (int r = 1; r <= 4; r++) tick(mk(1, 0, 0, r, 0, 0, 1, 0, 0, 0, 0), "fl_fill", 1'b1);
    tick(mk(1, 0, 0, 10, 0, 0, 1, 1, 1, 1, 0), "flush", 1'b1);
    tick(mk(0, 0, 0, 0, 0, 0, 0, 1, 12, 0, 0), "post_flush_uf", 1'b1);

    // Saturating stall statistics.
    tick(mk(1, 0, 0, 11, 0, 0, 1, 0, 0, 0, 0), "sc_setup", 1'b1);
    for (int i = 0; i < 70000; i++)
      tick(mk(1, 11, 0, 0, 1, 0, 0, 0, 0, 0, 1), "sc_run", (i == 0 || i == 69999));
    chk("sc_saturated", 32'(stall_cycles), 32'h0000_FFFF);

    // Async reset mid-cycle with x5 holding two pending writes.
    tick(mk(0, 0, 0, 0, 0, 0, 0, 1, 11, 0, 0), "rst_pre", 1'b1);
    tick(mk(1, 0, 0, 5, 0, 0, 1, 0, 0, 0, 0), "rst_w1", 1'b1);
    tick(mk(1, 0, 0, 5, 0, 0, 1, 0, 0, 0, 0), "rst_w2", 1'b1);
    @(negedge clk);
    issue_valid = 0; wb_valid = 0; flush = 0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("arst_busy",  busy_vec, '0);
    chk("arst_empty", 32'(sb_empty), 32'd1);
    chk("arst_sc",    32'(stall_cycles), 32'd0);
    chk("arst_err",   32'(err_underflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick(mk(1, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0), "post_rst", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
